// File: rtl/iob_timer_master.sv
// rtl/iob_timer_master.sv - timer bus initiator: SAMPLE reads the 64-bit count, CLEAR soft-resets it
// Optional feature macro: TIMER_MASTER_DELTA_EN (adds sample_delta and a previous-sample register)
module iob_timer_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic        cmd_op,
    output logic        cmd_ready,
    output logic        sample_valid,
    output logic [63:0] sample_data,
`ifdef TIMER_MASTER_DELTA_EN
    output logic [63:0] sample_delta,
`endif
    output logic        clear_done,
    output logic        timeout_err,
    output logic        m_valid,
    output logic [1:0]  m_address,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ready
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] A_RESET = 2'd0;
    localparam logic [1:0] A_STOP  = 2'd1;
    localparam logic [1:0] A_HIGH  = 2'd2;
    localparam logic [1:0] A_LOW   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_STOP, S_GAP1, S_RDHI, S_GAP2, S_RDLO, S_CLR
    } state_t;

    state_t        state_q, state_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          m_valid_q, m_valid_d;
    logic [1:0]    m_address_q, m_address_d;
    logic [31:0]   m_wdata_q, m_wdata_d;
    logic          sample_valid_q, sample_valid_d;
    logic [63:0]   sample_data_q, sample_data_d;
    logic          clear_done_q, clear_done_d;
    logic          timeout_err_q, timeout_err_d;
    logic [31:0]   hi_q, hi_d;
    logic [CW-1:0] to_cnt_q, to_cnt_d;
`ifdef TIMER_MASTER_DELTA_EN
    logic [63:0]   prev_q, prev_d;
    logic [63:0]   sample_delta_q, sample_delta_d;
`endif

    logic hs;
    assign hs = m_valid_q && m_ready;

    always_comb begin
        state_d        = state_q;
        m_valid_d      = m_valid_q;
        m_address_d    = m_address_q;
        m_wdata_d      = m_wdata_q;
        sample_valid_d = 1'b0;
        sample_data_d  = sample_data_q;
        clear_done_d   = 1'b0;
        timeout_err_d  = 1'b0;
        hi_d           = hi_q;
        to_cnt_d       = to_cnt_q;
`ifdef TIMER_MASTER_DELTA_EN
        prev_d         = prev_q;
        sample_delta_d = sample_delta_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    m_valid_d = 1'b1;
                    to_cnt_d  = '0;
                    if (cmd_op) begin
                        state_d     = S_CLR;
                        m_address_d = A_RESET;
                        m_wdata_d   = 32'h1;
                    end else begin
                        state_d     = S_STOP;
                        m_address_d = A_STOP;
                        m_wdata_d   = 32'h0;
                    end
                end
            end
            S_GAP1: begin
                state_d     = S_RDHI;
                m_valid_d   = 1'b1;
                m_address_d = A_HIGH;
                m_wdata_d   = 32'h0;
            end
            S_GAP2: begin
                state_d     = S_RDLO;
                m_valid_d   = 1'b1;
                m_address_d = A_LOW;
                m_wdata_d   = 32'h0;
            end
            S_STOP, S_RDHI, S_RDLO, S_CLR: begin
                // A handshake in the cycle the limit would be hit takes priority over the abort
                if (hs) begin
                    m_valid_d = 1'b0;
                    to_cnt_d  = '0;
                    case (state_q)
                        S_STOP: state_d = S_GAP1;
                        S_RDHI: begin
                            hi_d    = m_rdata;
                            state_d = S_GAP2;
                        end
                        S_RDLO: begin
                            sample_data_d  = {hi_q, m_rdata};
                            sample_valid_d = 1'b1;
                            state_d        = S_IDLE;
`ifdef TIMER_MASTER_DELTA_EN
                            sample_delta_d = {hi_q, m_rdata} - prev_q;
                            prev_d         = {hi_q, m_rdata};
`endif
                        end
                        default: begin
                            clear_done_d = 1'b1;
                            state_d      = S_IDLE;
`ifdef TIMER_MASTER_DELTA_EN
                            prev_d       = 64'h0;
`endif
                        end
                    endcase
                end else if (to_cnt_q == TO_LAST) begin
                    m_valid_d     = 1'b0;
                    timeout_err_d = 1'b1;
                    to_cnt_d      = '0;
                    state_d       = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        cmd_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cmd_ready_q    <= 1'b1;
            m_valid_q      <= 1'b0;
            m_address_q    <= 2'd0;
            m_wdata_q      <= 32'h0;
            sample_valid_q <= 1'b0;
            sample_data_q  <= 64'h0;
            clear_done_q   <= 1'b0;
            timeout_err_q  <= 1'b0;
            hi_q           <= 32'h0;
            to_cnt_q       <= '0;
`ifdef TIMER_MASTER_DELTA_EN
            prev_q         <= 64'h0;
            sample_delta_q <= 64'h0;
`endif
        end else begin
            state_q        <= state_d;
            cmd_ready_q    <= cmd_ready_d;
            m_valid_q      <= m_valid_d;
            m_address_q    <= m_address_d;
            m_wdata_q      <= m_wdata_d;
            sample_valid_q <= sample_valid_d;
            sample_data_q  <= sample_data_d;
            clear_done_q   <= clear_done_d;
            timeout_err_q  <= timeout_err_d;
            hi_q           <= hi_d;
            to_cnt_q       <= to_cnt_d;
`ifdef TIMER_MASTER_DELTA_EN
            prev_q         <= prev_d;
            sample_delta_q <= sample_delta_d;
`endif
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign sample_valid = sample_valid_q;
    assign sample_data  = sample_data_q;
    assign clear_done   = clear_done_q;
    assign timeout_err  = timeout_err_q;
    assign m_valid      = m_valid_q;
    assign m_address    = m_address_q;
    assign m_wdata      = m_wdata_q;
`ifdef TIMER_MASTER_DELTA_EN
    assign sample_delta = sample_delta_q;
`endif

endmodule

// File: tb/tb_iob_timer_master.sv
// tb/tb_iob_timer_master.sv - self-checking bench for iob_timer_master with a behavioural timer responder
module tb_iob_timer_master;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_op = 1'b0;
    logic        cmd_ready;
    logic        sample_valid;
    logic [63:0] sample_data;
`ifdef TIMER_MASTER_DELTA_EN
    logic [63:0] sample_delta;
`endif
    logic        clear_done;
    logic        timeout_err;
    logic        m_valid;
    logic [1:0]  m_address;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = 32'h0;
    logic        m_ready = 1'b0;

    iob_timer_master #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
        .sample_valid(sample_valid), .sample_data(sample_data),
`ifdef TIMER_MASTER_DELTA_EN
        .sample_delta(sample_delta),
`endif
        .clear_done(clear_done), .timeout_err(timeout_err),
        .m_valid(m_valid), .m_address(m_address), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Responder: ready is raised once valid has been seen for 2+r_wait cycles; r_stuck names an address that never answers
    int          r_wait = 0;
    int          r_stuck = 4;
    logic [31:0] r_hi = 32'h0;
    logic [31:0] r_lo = 32'h0;
    int          vcnt = 0;
    logic [1:0]  hs_addr[$];
    logic [31:0] hs_wdata[$];
    int          gap_err = 0;
    int          stab_err = 0;
    logic        prev_v = 1'b0;
    logic        prev_hs = 1'b0;
    logic [1:0]  prev_a = 2'd0;
    logic [31:0] prev_w = 32'h0;

    always @(negedge clk) begin
        if (rst || !m_valid) begin
            vcnt    = 0;
            m_ready = 1'b0;
        end else begin
            vcnt++;
            m_ready = (int'(m_address) != r_stuck) && (vcnt >= 2 + r_wait);
            m_rdata = (m_address == 2'd2) ? r_hi : (m_address == 2'd3) ? r_lo : $urandom;
        end
        if (!rst) begin
            if (m_valid && prev_hs) gap_err++;
            if (m_valid && prev_v && !prev_hs && (m_address != prev_a || m_wdata != prev_w)) stab_err++;
            if (m_valid && m_ready) begin
                hs_addr.push_back(m_address);
                hs_wdata.push_back(m_wdata);
            end
        end
        prev_v  = m_valid && !rst;
        prev_hs = m_valid && m_ready && !rst;
        prev_a  = m_address;
        prev_w  = m_wdata;
    end

    logic [63:0] model_data = 64'h0;
    logic [63:0] model_prev = 64'h0;
    logic [63:0] model_delta = 64'h0;

    // Called and returns at a negedge; op 0 = SAMPLE, 1 = CLEAR; cmd_valid is held until completion
    task automatic run_op(input bit op, input logic [31:0] hi, input logic [31:0] lo,
                          input int w, input int stuck);
        int  addrs[$];
        int  t = 0;
        int  pulse_t = 0;
        int  n_ok = 0;
        bit  exp_to = 0;
        int  k = 0;
        int  guard = 0;
        bit  got = 0;
        bit  early = 0;
        logic sv = 0, cd = 0, te = 0, cr = 0;

        if (op) addrs = '{0}; else addrs = '{1, 2, 3};
        for (int i = 0; i < addrs.size(); i++) begin
            if (!exp_to) begin
                if (addrs[i] == stuck || w + 1 >= T) begin
                    exp_to  = 1;
                    pulse_t = t + T + 1;
                end else begin
                    t += 2 + w;
                    n_ok++;
                    if (i == addrs.size() - 1) pulse_t = t + 1;
                    else t += 1;
                end
            end
        end

        r_wait = w; r_stuck = stuck; r_hi = hi; r_lo = lo;
        hs_addr.delete(); hs_wdata.delete();
        cmd_valid = 1'b1;
        cmd_op    = op;
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("cmd_accept", 64'(cmd_ready), 64'(1));
        @(posedge clk);
        while (!got && k < pulse_t + 40) begin
            @(negedge clk);
            k++;
            if (sample_valid || clear_done || timeout_err) begin
                got = 1;
                sv = sample_valid; cd = clear_done; te = timeout_err; cr = cmd_ready;
                cmd_valid = 1'b0;
            end else if (cmd_ready) begin
                early = 1;
            end
        end
        cmd_valid = 1'b0;

        chk("latency", 64'(k), 64'(pulse_t));
        chk("sample_valid", 64'(sv), 64'(!op && !exp_to));
        chk("clear_done", 64'(cd), 64'(op && !exp_to));
        chk("timeout_err", 64'(te), 64'(exp_to));
        chk("cmd_ready_done", 64'(cr), 64'(1));
        chk("cmd_ready_busy", 64'(early), 64'(0));
        chk("n_handshakes", 64'(hs_addr.size()), 64'(n_ok));
        for (int i = 0; i < hs_addr.size() && i < n_ok; i++) begin
            chk("hs_addr", 64'(hs_addr[i]), 64'(addrs[i]));
            chk("hs_wdata", 64'(hs_wdata[i]), op ? 64'h1 : 64'h0);
        end
        if (!exp_to) begin
            if (!op) begin
                model_data  = {hi, lo};
                model_delta = model_data - model_prev;
                model_prev  = model_data;
            end else begin
                model_prev = 64'h0;
            end
        end
        chk("sample_data", sample_data, model_data);
`ifdef TIMER_MASTER_DELTA_EN
        chk("sample_delta", sample_delta, model_delta);
`endif
        @(negedge clk);
        chk("pulse_width", 64'({sample_valid, clear_done, timeout_err}), 64'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        bit op;
        int r;
        int w;
        int stuck;

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("rst_outputs", 64'({m_valid, sample_valid, clear_done, timeout_err}), 64'(0));
        chk("rst_bus", {30'h0, m_address, m_wdata}, 64'h0);
        chk("rst_sample_data", sample_data, 64'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", 64'(cmd_ready), 64'(1));

        run_op(0, 32'h0000_0001, 32'h0000_0010, 0, 4);
        run_op(1, 32'h0, 32'h0, 0, 4);
        run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1, 4);
        run_op(0, 32'h0, 32'h5, 0, 4);
        run_op(1, 32'h0, 32'h0, 2, 4);
        run_op(0, 32'h0, 32'h20, 0, 4);
        run_op(0, 32'hDEAD_BEEF, 32'h1234_5678, 15, 4);
        run_op(0, 32'hCAFE_0001, 32'h0000_0042, 14, 4);
        run_op(0, 32'h1111_1111, 32'h2222_2222, 0, 2);
        run_op(1, 32'h0, 32'h0, 0, 0);
        run_op(0, 32'h0000_0003, 32'h0000_0007, 0, 3);

        cmd_valid = 1'b1;
        cmd_op    = 1'b0;
        r_wait = 0; r_stuck = 4;
        guard = 0;
        while (!(m_valid && m_address == 2'd2) && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        chk("rst_reach_rdhi", 64'(m_valid && m_address == 2'd2), 64'(1));
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_m_valid", 64'(m_valid), 64'(0));
        chk("midrst_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("midrst_sample_valid", 64'(sample_valid), 64'(0));
        chk("midrst_sample_data", sample_data, 64'h0);
        rst = 1'b0;
        model_data = 64'h0; model_prev = 64'h0; model_delta = 64'h0;
        guard = 0;
        repeat (4) begin
            @(negedge clk);
            if (sample_valid || m_valid) guard++;
        end
        chk("midrst_quiet", 64'(guard), 64'(0));

        for (int i = 0; i < 24; i++) begin
            op = ($urandom_range(0, 3) == 0);
            r  = $urandom_range(0, 9);
            w  = (r < 7) ? $urandom_range(0, 3) : (r == 7) ? 14 : 15;
            stuck = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : 4;
            run_op(op, $urandom, $urandom, w, stuck);
        end

        chk("gap_violations", 64'(gap_err), 64'(0));
        chk("stability_violations", 64'(stab_err), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iob_timer_master.md
# iob_timer_master

Bus initiator that drives the timer peripheral's CPU interface (valid/address/wdata/rdata/ready) on behalf of a hardware client. On command it either latches and reads the 64-bit cycle count (STOP, then DATA_HIGH, then DATA_LOW) or issues a soft counter reset. It sits between a hardware consumer (profiler, trace unit) and the timer, and lets that consumer take timestamps without CPU involvement.

## Interface
- TIMEOUT_CYCLES, 16, maximum cycles `m_valid` is held without `m_ready` before the transaction is aborted (≥2)
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  command request
- cmd_op  input  1  0 = SAMPLE, 1 = CLEAR
- cmd_ready  output  1  high in IDLE only; command accepted on `cmd_valid && cmd_ready`
- sample_valid  output  1  one-cycle pulse: `sample_data` updated
- sample_data  output  64  last sampled count, held until the next sample
- sample_delta  output  64  `sample_data` minus previous sample (present only with `TIMER_MASTER_DELTA_EN`)
- clear_done  output  1  one-cycle pulse: CLEAR completed
- timeout_err  output  1  one-cycle pulse: a transaction was aborted
- m_valid  output  1  bus request
- m_address  output  2  timer register: 0 RESET, 1 STOP, 2 DATA_HIGH, 3 DATA_LOW
- m_wdata  output  32  write data
- m_rdata  input  32  read data, valid while `m_valid && m_ready`
- m_ready  input  1  responder acknowledge

One clock; reset is synchronous and active-high.

## Operation
- States: IDLE, STOP, GAP1, RDHI, GAP2, RDLO, CLR.
- IDLE: `cmd_ready=1`, `m_valid=0`. Accept SAMPLE → STOP; accept CLEAR → CLR.
- Bus transaction: `m_valid`, `m_address`, and `m_wdata` are held stable until the cycle in which `m_ready=1` (the handshake cycle), and `m_valid` drops in the next cycle. `m_valid` is low for at least one cycle between transactions, because the responder's ready is registered from valid.
- STOP: address 1, wdata 0 → GAP1 (one cycle, `m_valid=0`) → RDHI: address 2, capture `m_rdata` into the high half on handshake → GAP2 → RDLO: address 3, capture the low half on handshake → IDLE, pulse `sample_valid`, and update `sample_data` in the same cycle.
- CLR: address 0, wdata 32'h1 → IDLE, pulse `clear_done`.
- `m_wdata` is 0 for all non-RESET transactions.
- `cmd_valid` while busy is not accepted; there is no queueing.
- Timeout: a per-transaction counter counts cycles with `m_valid && !m_ready`. When it reaches TIMEOUT_CYCLES: drop `m_valid`, pulse `timeout_err`, return to IDLE, and leave `sample_data` unchanged (a partial high word is discarded). If `m_ready` arrives in the same cycle the limit is reached, the handshake wins and no error is raised.
- Reset values: all outputs 0 except `cmd_ready=1` in the first cycle after reset. State is IDLE and the timeout counter is 0.
- Reset mid-operation: `m_valid` drops on the next edge, the state returns to IDLE, and no completion pulse is produced.

## Timing
- Zero-wait responder (ready one cycle after valid), SAMPLE accepted at edge E0:
  - STOP valid in C1–C2, gap C3.
  - DATA_HIGH valid in C4–C5, gap C6.
  - DATA_LOW valid in C7–C8.
  - `sample_valid` and `cmd_ready` high in C9, giving 9 cycles of latency.
- CLEAR: valid in C1–C2; `clear_done` and `cmd_ready` in C3.
- A new command accepted in C9 asserts `m_valid` in C10, so back-to-back samples repeat every 9 cycles.
- Each added responder wait cycle adds one cycle of latency.

## Configuration
- `TIMER_MASTER_DELTA_EN` defined:
  - The `sample_delta` port and a 64-bit previous-sample register exist.
  - On each `sample_valid`, `sample_delta = new - prev` modulo 2^64, so wrap-around produces the small positive difference. `prev` is then set to the new value.
  - `prev` is cleared to 0 by `rst` and by a completed CLEAR. The first sample after either event therefore yields `delta = sample_data`.
- Undefined: no `sample_delta` port and no previous-sample register; all other behaviour is identical.

## Test plan
- Zero-wait responder returning high 32'h00000001 and low 32'h00000010: SAMPLE → bus sequence at addresses 1, 2, 3 with one-cycle gaps; `sample_data` = 64'h0000_0001_0000_0010; `sample_valid` in C9.
- CLEAR → exactly one transaction to address 0 with wdata 32'h1; `clear_done` in C3. `cmd_valid` held during the operation is accepted only in C3.
- Responder never asserts ready, TIMEOUT_CYCLES=16 → `m_valid` high for 16 cycles, then `timeout_err` pulses; `sample_data` unchanged; IDLE next.
- Ready arrives exactly on the 16th wait cycle → handshake completes with no `timeout_err`.
- `rst` asserted during RDHI → `m_valid` = 0 the next cycle; no `sample_valid`; `cmd_ready` = 1.
- With `TIMER_MASTER_DELTA_EN`: samples 64'hFFFF_FFFF_FFFF_FFF0 then 64'h5 → `sample_delta` = 64'h15. After a CLEAR, a sample of 64'h20 gives delta 64'h20.
